// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter (5..8 data bits, optional parity, 1 or 2 stop bits)
// fed by a small power-of-two FIFO so frames go out back-to-back without caller polling.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] txbyte,
    input  logic                 senddata,
    output logic                 ready,
    output logic                 txdone,
    output logic                 busy,
    output logic                 overflow,
    output logic                 tx
);

    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W    = PTR_W + 1;

    if (BAUD_DIV < 2) begin : g_chk_div
        $error("uart_tx_fifo: CLK_HZ / BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Odd parity is the inverse of the even (XOR) parity of the data bits.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]     count_r;
    state_t               state_r;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [3:0]           bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_r;
    logic                 tx_r;
    logic                 txdone_r;
    logic                 overflow_r;

    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_nempty_s;
    logic                 bit_end_s;
    logic                 last_stop_s;
    logic [DATA_BITS-1:0] head_s;

    // Handshake, pop decision and status derived from registered state.
    always_comb begin
        fifo_nempty_s = (count_r != LVL_W'(0));
        ready         = (count_r != LVL_W'(FIFO_DEPTH));
        push_s        = senddata && ready;
        bit_end_s     = (baud_cnt_r == CNT_W'(BAUD_DIV - 1));
        last_stop_s   = (state_r == ST_STOP) && bit_end_s &&
                        (bit_cnt_r == 4'(STOP_BITS - 1));
        pop_s         = fifo_nempty_s && ((state_r == ST_IDLE) || last_stop_s);
        head_s        = mem_r[rd_ptr_r];
        busy          = (state_r != ST_IDLE) || fifo_nempty_s;
    end

    assign tx       = tx_r;
    assign txdone   = txdone_r;
    assign overflow = overflow_r;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= txbyte;
        end
    end

    // FIFO pointers and fill level; simultaneous push and pop keep the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= LVL_W'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + LVL_W'(1);
            end else if (!push_s && pop_s) begin
                count_r <= count_r - LVL_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Sticky overflow on a push attempt while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (senddata && !ready) begin
            overflow_r <= 1'b1;
        end
    end

    // Frame FSM: start, data LSB first, optional parity, stop; reloads from the FIFO
    // on the last stop edge so consecutive frames have no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_W'(0);
            bit_cnt_r  <= 4'd0;
            shift_r    <= '0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            txdone_r   <= 1'b0;
        end else begin
            txdone_r   <= 1'b0;
            baud_cnt_r <= (state_r == ST_IDLE || bit_end_s) ? CNT_W'(0)
                                                           : baud_cnt_r + CNT_W'(1);
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_r   <= head_s;
                        parity_r  <= parity_bit(head_s);
                        bit_cnt_r <= 4'd0;
                        tx_r      <= 1'b0;
                        state_r   <= ST_START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
                            bit_cnt_r <= 4'd0;
                            if (PARITY != 0) begin
                                tx_r    <= parity_r;
                                state_r <= ST_PARITY;
                            end else begin
                                tx_r    <= 1'b1;
                                state_r <= ST_STOP;
                            end
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        tx_r      <= 1'b1;
                        bit_cnt_r <= 4'd0;
                        state_r   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_stop_s) begin
                        txdone_r  <= 1'b1;
                        bit_cnt_r <= 4'd0;
                        if (fifo_nempty_s) begin
                            shift_r  <= head_s;
                            parity_r <= parity_bit(head_s);
                            tx_r     <= 1'b0;
                            state_r  <= ST_START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else if (bit_end_s) begin
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four builds at 8 clocks per bit (8N1, 8E1, 8O1, 7N2),
// checking every bit time of each frame against hand-composed frame vectors.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] send = 4'b0000;
    logic [7:0] txbyte = 8'h00;
    logic [3:0] tx_w, txdone_w, busy_w, ready_w, ovf_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(800), .BAUD(100)) u_8n1 (
        .clk(clk), .rst(rst), .txbyte(txbyte), .senddata(send[0]),
        .ready(ready_w[0]), .txdone(txdone_w[0]), .busy(busy_w[0]),
        .overflow(ovf_w[0]), .tx(tx_w[0]));

    uart_tx_fifo #(.CLK_HZ(800), .BAUD(100), .PARITY(2)) u_8e1 (
        .clk(clk), .rst(rst), .txbyte(txbyte), .senddata(send[1]),
        .ready(ready_w[1]), .txdone(txdone_w[1]), .busy(busy_w[1]),
        .overflow(ovf_w[1]), .tx(tx_w[1]));

    uart_tx_fifo #(.CLK_HZ(800), .BAUD(100), .PARITY(1)) u_8o1 (
        .clk(clk), .rst(rst), .txbyte(txbyte), .senddata(send[2]),
        .ready(ready_w[2]), .txdone(txdone_w[2]), .busy(busy_w[2]),
        .overflow(ovf_w[2]), .tx(tx_w[2]));

    uart_tx_fifo #(.CLK_HZ(800), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .txbyte(txbyte[6:0]), .senddata(send[3]),
        .ready(ready_w[3]), .txdone(txdone_w[3]), .busy(busy_w[3]),
        .overflow(ovf_w[3]), .tx(tx_w[3]));

    task automatic test_reset();
        rst  = 1'b1;
        send = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (tx_w[i] !== 1'b1 || txdone_w[i] !== 1'b0 || ovf_w[i] !== 1'b0 ||
                ready_w[i] !== 1'b1 || busy_w[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset inst=%0d tx/txdone/ovf/ready/busy=%b%b%b%b%b expected 10010",
                         i, tx_w[i], txdone_w[i], ovf_w[i], ready_w[i], busy_w[i]);
            end
        end
    endtask

    // One push into an idle DUT; exp_bits[k] is the line level during bit time k.
    task automatic test_single_frame(input int inst, input logic [7:0] data,
                                     input logic [11:0] exp_bits, input int nbits,
                                     input string name);
        int   len;
        logic e_tx, e_done, e_busy;
        len = nbits * 8;
        for (int t = 0; t <= len + 3; t++) begin
            @(negedge clk);
            if (t >= 2 && t < len + 2) begin
                e_tx = exp_bits[(t - 2) / 8];
            end else begin
                e_tx = 1'b1;
            end
            e_done = (t == len + 2);
            e_busy = (t >= 1 && t < len + 2);
            n_tests++;
            if (tx_w[inst] !== e_tx) begin
                n_fail++;
                $display("FAIL %s_tx t=%0d got %b expected %b", name, t, tx_w[inst], e_tx);
            end
            n_tests++;
            if (txdone_w[inst] !== e_done) begin
                n_fail++;
                $display("FAIL %s_txdone t=%0d got %b expected %b", name, t, txdone_w[inst], e_done);
            end
            n_tests++;
            if (busy_w[inst] !== e_busy) begin
                n_fail++;
                $display("FAIL %s_busy t=%0d got %b expected %b", name, t, busy_w[inst], e_busy);
            end
            send[inst] = (t == 0);
            txbyte     = data;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic [9:0] fr;
        logic       e_tx, e_done, e_busy;
        int         f, k;
        bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        for (int t = 0; t <= 410; t++) begin
            @(negedge clk);
            e_tx = 1'b1;
            if (t >= 2 && t < 402) begin
                f    = (t - 2) / 80;
                k    = (t - 2) % 80;
                fr   = {1'b1, bytes[f], 1'b0};
                e_tx = fr[k / 8];
            end
            e_done = (t >= 82 && t <= 402 && ((t - 2) % 80) == 0);
            e_busy = (t >= 1 && t < 402);
            n_tests++;
            if (tx_w[0] !== e_tx) begin
                n_fail++;
                $display("FAIL b2b_tx t=%0d got %b expected %b", t, tx_w[0], e_tx);
            end
            n_tests++;
            if (txdone_w[0] !== e_done) begin
                n_fail++;
                $display("FAIL b2b_txdone t=%0d got %b expected %b", t, txdone_w[0], e_done);
            end
            n_tests++;
            if (busy_w[0] !== e_busy) begin
                n_fail++;
                $display("FAIL b2b_busy t=%0d got %b expected %b", t, busy_w[0], e_busy);
            end
            n_tests++;
            if (ovf_w[0] !== (t >= 6)) begin
                n_fail++;
                $display("FAIL b2b_overflow t=%0d got %b expected %b", t, ovf_w[0], (t >= 6));
            end
            if (t <= 6) begin
                n_tests++;
                if (ready_w[0] !== (t < 5)) begin
                    n_fail++;
                    $display("FAIL b2b_ready t=%0d got %b expected %b", t, ready_w[0], (t < 5));
                end
            end
            send[0] = (t < 6);
            txbyte  = (t < 6) ? bytes[t] : 8'h00;
        end
    endtask

    // Reset lands in the third data bit of a 0xFF frame (frame cycle 26).
    task automatic test_reset_midframe();
        for (int t = 0; t <= 130; t++) begin
            @(negedge clk);
            if (t == 0) begin
                n_tests++;
                if (ovf_w[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midrst_ovf_before got %b expected 1", ovf_w[0]);
                end
            end
            if (t == 28) begin
                n_tests++;
                if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL midrst_in_frame tx/busy=%b%b expected 11", tx_w[0], busy_w[0]);
                end
            end
            if (t == 29) begin
                n_tests++;
                if (ready_w[0] !== 1'b1 || ovf_w[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_flags ready/ovf=%b%b expected 10", ready_w[0], ovf_w[0]);
                end
            end
            if (t >= 29) begin
                n_tests++;
                if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || txdone_w[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_after t=%0d tx/busy/txdone=%b%b%b expected 100",
                             t, tx_w[0], busy_w[0], txdone_w[0]);
                end
            end
            send[0] = (t == 0);
            txbyte  = 8'hFF;
            rst     = (t == 28);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            n_tests++;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || txdone_w[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle t=%0d tx/busy/txdone=%b%b%b expected 100",
                         t, tx_w[0], busy_w[0], txdone_w[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(0, 8'h55, {2'b00, 1'b1, 8'h55, 1'b0}, 10, "8n1_55");
        test_single_frame(1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "8e1_07");
        test_single_frame(2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, "8o1_07");
        test_single_frame(3, 8'h3F, {2'b00, 2'b11, 7'h3F, 1'b0}, 10, "7n2_3f");
        test_back_to_back();
        test_reset_midframe();
        test_single_frame(0, 8'h12, {2'b00, 1'b1, 8'h12, 1'b0}, 10, "after_rst_12");
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
